// File: rtl/rob_retire_queue_pkg.sv
// Shared types and widths for the reorder buffer and its retire selector.
package rob_retire_queue_pkg;
  localparam int unsigned PRF_DEF       = 64;
  localparam int unsigned ROB_DEPTH_DEF = 32;
  localparam int unsigned ROB_IDX_W     = $clog2(ROB_DEPTH_DEF);
  localparam int unsigned PRF_IDX_W     = $clog2(PRF_DEF);

  typedef struct packed {
    logic                 valid;
    logic                 complete;
    logic                 mispredict;
    logic                 has_dest;
    logic [4:0]           arf_idx;
    logic [PRF_IDX_W-1:0] prf_idx;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_select.sv
// Picks the in-order run of completed head entries that retire this cycle.
module rob_retire_select
  import rob_retire_queue_pkg::*;
#(
  parameter int unsigned WAYS = 4
) (
  input  rob_entry_t [WAYS-1:0]                 head_entries,
  output logic       [WAYS-1:0]                 retire_mask,
  output logic       [WAYS-1:0][4:0]            rrat_arf_idx,
  output logic       [WAYS-1:0][PRF_IDX_W-1:0]  rrat_prf_idx,
  output logic       [WAYS-1:0]                 rrat_idx_valid,
  output logic                                  except,
  output logic       [$clog2(WAYS+1)-1:0]       retire_count
);
  localparam int unsigned CW = $clog2(WAYS+1);

  logic chain;

  always_comb begin
    retire_mask    = '0;
    rrat_arf_idx   = '0;
    rrat_prf_idx   = '0;
    rrat_idx_valid = '0;
    except         = 1'b0;
    retire_count   = '0;
    chain          = 1'b1;
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (chain && head_entries[k].valid && head_entries[k].complete) begin
        retire_mask[k]    = 1'b1;
        rrat_arf_idx[k]   = head_entries[k].arf_idx;
        rrat_prf_idx[k]   = head_entries[k].prf_idx;
        rrat_idx_valid[k] = head_entries[k].has_dest && (head_entries[k].arf_idx != 5'd0);
        retire_count      = retire_count + CW'(1);
        // A mispredicted branch retires itself but blocks every younger lane.
        if (head_entries[k].mispredict) begin
          except = 1'b1;
          chain  = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rob_retire_queue.sv
// In-order reorder buffer: dispatch allocation, CDB completion, in-order retire and flush.
module rob_retire_queue
  import rob_retire_queue_pkg::*;
#(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned PRF       = PRF_DEF,
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [WAYS-1:0]                           disp_valid,
  input  logic [WAYS-1:0][4:0]                      disp_arf_idx,
  input  logic [WAYS-1:0][$clog2(PRF)-1:0]          disp_prf_idx,
  input  logic [WAYS-1:0]                           disp_has_dest,
  output logic [WAYS-1:0]                           disp_accept,
  output logic [WAYS-1:0][$clog2(ROB_DEPTH)-1:0]    disp_rob_idx,
  input  logic [WAYS-1:0]                           cdb_valid,
  input  logic [WAYS-1:0][$clog2(ROB_DEPTH)-1:0]    cdb_rob_idx,
  input  logic [WAYS-1:0]                           cdb_mispredict,
  output logic [WAYS-1:0][4:0]                      RRAT_ARF_idx,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]          RRAT_PRF_idx,
  output logic [WAYS-1:0]                           RRAT_idx_valid,
  output logic                                      except,
  output logic [$clog2(WAYS+1)-1:0]                 retire_count,
  output logic [$clog2(ROB_DEPTH+1)-1:0]            free_slots
);
  localparam int unsigned IW = $clog2(ROB_DEPTH);
  localparam int unsigned CW = $clog2(WAYS+1);
  localparam int unsigned FW = $clog2(ROB_DEPTH+1);

  rob_entry_t                entries [ROB_DEPTH];
  logic       [IW-1:0]       head;
  logic       [IW-1:0]       tail;
  logic       [FW-1:0]       count;
  logic       [FW-1:0]       free_q;
  logic       [FW-1:0]       count_next;
  logic       [CW-1:0]       acc_cnt;
  rob_entry_t [WAYS-1:0]     head_entries;
  logic       [WAYS-1:0]     retire_mask;

  assign free_slots = free_q;

  // Admission uses only the registered free count, so a slot being retired this
  // cycle can never be reallocated in the same cycle.
  always_comb begin
    acc_cnt = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      disp_rob_idx[i] = tail + IW'(i);
      disp_accept[i]  = disp_valid[i] && (FW'(i) < free_q) && !except;
      if (disp_accept[i]) acc_cnt = acc_cnt + CW'(1);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < WAYS; k++) begin
      head_entries[k] = entries[head + IW'(k)];
    end
  end

  assign count_next = count + FW'(acc_cnt) - FW'(retire_count);

  rob_retire_select #(
    .WAYS (WAYS)
  ) u_select (
    .head_entries   (head_entries),
    .retire_mask    (retire_mask),
    .rrat_arf_idx   (RRAT_ARF_idx),
    .rrat_prf_idx   (RRAT_PRF_idx),
    .rrat_idx_valid (RRAT_idx_valid),
    .except         (except),
    .retire_count   (retire_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      free_q <= FW'(ROB_DEPTH);
      for (int unsigned d = 0; d < ROB_DEPTH; d++) entries[d] <= '0;
    end else if (except) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      free_q <= FW'(ROB_DEPTH);
      for (int unsigned d = 0; d < ROB_DEPTH; d++) entries[d] <= '0;
    end else begin
      // Write order matters: retire clears override a late duplicate completion,
      // and dispatch only ever targets free slots.
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (cdb_valid[w] && entries[cdb_rob_idx[w]].valid) begin
          entries[cdb_rob_idx[w]].complete <= 1'b1;
          if (cdb_mispredict[w]) entries[cdb_rob_idx[w]].mispredict <= 1'b1;
        end
      end
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (retire_mask[k]) entries[head + IW'(k)] <= '0;
      end
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (disp_accept[i]) begin
          entries[disp_rob_idx[i]] <= '{valid:      1'b1,
                                        complete:   1'b0,
                                        mispredict: 1'b0,
                                        has_dest:   disp_has_dest[i],
                                        arf_idx:    disp_arf_idx[i],
                                        prf_idx:    disp_prf_idx[i]};
        end
      end
      head   <= head + IW'(retire_count);
      tail   <= tail + IW'(acc_cnt);
      count  <= count_next;
      free_q <= FW'(ROB_DEPTH) - count_next;
    end
  end
endmodule

// File: tb/tb_rob_retire_queue.sv
// Directed-vector bench for rob_retire_queue with hand-computed expectations.
module tb_rob_retire_queue;
  localparam int unsigned WAYS = 4;

  logic                 clock;
  logic                 reset;
  logic [3:0]           disp_valid;
  logic [3:0][4:0]      disp_arf_idx;
  logic [3:0][5:0]      disp_prf_idx;
  logic [3:0]           disp_has_dest;
  logic [3:0]           disp_accept;
  logic [3:0][4:0]      disp_rob_idx;
  logic [3:0]           cdb_valid;
  logic [3:0][4:0]      cdb_rob_idx;
  logic [3:0]           cdb_mispredict;
  logic [3:0][4:0]      RRAT_ARF_idx;
  logic [3:0][5:0]      RRAT_PRF_idx;
  logic [3:0]           RRAT_idx_valid;
  logic                 except;
  logic [2:0]           retire_count;
  logic [5:0]           free_slots;

  int checks = 0;
  int errors = 0;

  rob_retire_queue #(
    .WAYS      (4),
    .PRF       (64),
    .ROB_DEPTH (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .disp_valid     (disp_valid),
    .disp_arf_idx   (disp_arf_idx),
    .disp_prf_idx   (disp_prf_idx),
    .disp_has_dest  (disp_has_dest),
    .disp_accept    (disp_accept),
    .disp_rob_idx   (disp_rob_idx),
    .cdb_valid      (cdb_valid),
    .cdb_rob_idx    (cdb_rob_idx),
    .cdb_mispredict (cdb_mispredict),
    .RRAT_ARF_idx   (RRAT_ARF_idx),
    .RRAT_PRF_idx   (RRAT_PRF_idx),
    .RRAT_idx_valid (RRAT_idx_valid),
    .except         (except),
    .retire_count   (retire_count),
    .free_slots     (free_slots)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and leave inputs idle.
  task automatic tick();
    @(posedge clock);
    #1;
    disp_valid     = '0;
    cdb_valid      = '0;
    cdb_mispredict = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic disp(input logic [3:0] v, input int arf_base, input int prf_base);
    disp_valid = v;
    for (int i = 0; i < 4; i++) begin
      disp_arf_idx[i]  = 5'(arf_base + i);
      disp_prf_idx[i]  = 6'(prf_base + i);
      disp_has_dest[i] = 1'b1;
    end
  endtask

  task automatic cdb(input logic [3:0] v, input int i0, input int i1, input int i2, input int i3,
                     input logic [3:0] mp);
    cdb_valid      = v;
    cdb_rob_idx[0] = 5'(i0);
    cdb_rob_idx[1] = 5'(i1);
    cdb_rob_idx[2] = 5'(i2);
    cdb_rob_idx[3] = 5'(i3);
    cdb_mispredict = mp;
  endtask

  // Dispatch 30 entries from an empty ROB at tail 0.
  task automatic fill30();
    for (int c = 0; c < 7; c++) begin
      disp(4'hF, 1 + (4 * c) % 28, 4 * c);
      tick();
    end
    disp(4'h3, 29, 28);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    disp_valid = '0; disp_arf_idx = '0; disp_prf_idx = '0; disp_has_dest = '0;
    cdb_valid = '0; cdb_rob_idx = '0; cdb_mispredict = '0;
    tick(); tick();
    check("rst_free", 64'(free_slots), 64'd32);
    check("rst_rrat_v", 64'(RRAT_idx_valid), 64'h0);
    check("rst_except", 64'(except), 64'h0);
    check("rst_retire", 64'(retire_count), 64'h0);
    reset = 1'b1;
    tick();

    // Four lanes, lane 3 has no destination.
    disp(4'hF, 1, 10);
    disp_arf_idx[3]  = 5'd0;
    disp_has_dest[3] = 1'b0;
    settle();
    check("b_accept", 64'(disp_accept), 64'hF);
    check("b_rob_idx3", 64'(disp_rob_idx[3]), 64'd3);
    tick();
    check("b_free", 64'(free_slots), 64'd28);
    cdb(4'hF, 0, 1, 2, 3, 4'h0);
    settle();
    check("b_latency", 64'(retire_count), 64'd0);
    tick();
    check("b_retire", 64'(retire_count), 64'd4);
    check("b_rrat_v", 64'(RRAT_idx_valid), 64'h7);
    check("b_prf0", 64'(RRAT_PRF_idx[0]), 64'd10);
    check("b_prf2", 64'(RRAT_PRF_idx[2]), 64'd12);
    check("b_arf1", 64'(RRAT_ARF_idx[1]), 64'd2);
    tick();
    check("b_free_after", 64'(free_slots), 64'd32);
    check("b_tail", 64'(disp_rob_idx[0]), 64'd4);

    // Out-of-order completion: entry 5 held back.
    disp(4'hF, 5, 20);
    tick();
    cdb(4'h7, 4, 6, 7, 0, 4'h0);
    tick();
    cdb(4'h1, 5, 0, 0, 0, 4'h0);
    settle();
    check("c_retire1", 64'(retire_count), 64'd1);
    check("c_rrat_v1", 64'(RRAT_idx_valid), 64'h1);
    check("c_prf0", 64'(RRAT_PRF_idx[0]), 64'd20);
    tick();
    check("c_retire3", 64'(retire_count), 64'd3);
    check("c_rrat_v3", 64'(RRAT_idx_valid), 64'h7);
    check("c_prf0b", 64'(RRAT_PRF_idx[0]), 64'd21);
    tick();
    check("c_head", 64'(disp_rob_idx[0]), 64'd8);

    // Mispredict on entry 9 (lane 1) flushes everything.
    disp(4'hF, 1, 30);
    tick();
    cdb(4'hF, 8, 9, 10, 11, 4'h2);
    tick();
    disp(4'hF, 1, 50);
    settle();
    check("d_retire", 64'(retire_count), 64'd2);
    check("d_rrat_v", 64'(RRAT_idx_valid), 64'h3);
    check("d_except", 64'(except), 64'h1);
    check("d_accept", 64'(disp_accept), 64'h0);
    tick();
    check("d_free", 64'(free_slots), 64'd32);
    check("d_tail", 64'(disp_rob_idx[0]), 64'd0);
    check("d_except_clr", 64'(except), 64'h0);
    cdb(4'h3, 10, 11, 0, 0, 4'h0);
    tick();
    check("d_stale_cdb", 64'(free_slots), 64'd32);
    check("d_stale_ret", 64'(retire_count), 64'd0);

    // Fill to 30, then only two of four lanes fit.
    fill30();
    check("e_free30", 64'(free_slots), 64'd2);
    disp(4'hF, 1, 60);
    settle();
    check("e_accept", 64'(disp_accept), 64'h3);
    check("e_rob_idx1", 64'(disp_rob_idx[1]), 64'd31);
    tick();
    check("e_free0", 64'(free_slots), 64'd0);
    check("e_tail_wrap", 64'(disp_rob_idx[0]), 64'd0);
    disp(4'hF, 1, 60);
    settle();
    check("e_full_acc", 64'(disp_accept), 64'h0);
    tick();

    // Asynchronous reset mid-cycle with 10 entries held.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    disp(4'hF, 1, 0); tick();
    disp(4'hF, 5, 4); tick();
    disp(4'h3, 9, 8); tick();
    cdb(4'hF, 0, 1, 2, 3, 4'h0);
    tick();
    check("f_free22", 64'(free_slots), 64'd22);
    check("f_pre_rrat", 64'(RRAT_idx_valid), 64'hF);
    #2;
    reset = 1'b0;
    #1;
    check("f_async_free", 64'(free_slots), 64'd32);
    check("f_async_rrat", 64'(RRAT_idx_valid), 64'h0);
    check("f_async_exc", 64'(except), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    check("f_tail0", 64'(disp_rob_idx[0]), 64'd0);
    check("f_free32", 64'(free_slots), 64'd32);

    // Move head to 30, then retire across the wrap.
    fill30();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) cdb_rob_idx[i] = 5'(4 * c + i);
      cdb_valid = (c == 7) ? 4'h3 : 4'hF;
      tick();
    end
    for (int n = 0; n < 20 && free_slots != 6'd32; n++) tick();
    check("g_drained", 64'(free_slots), 64'd32);
    check("g_tail30", 64'(disp_rob_idx[0]), 64'd30);
    disp(4'hF, 9, 40);
    settle();
    check("g_rob_idx2", 64'(disp_rob_idx[2]), 64'd0);
    check("g_rob_idx3", 64'(disp_rob_idx[3]), 64'd1);
    tick();
    cdb(4'hF, 30, 31, 0, 1, 4'h0);
    tick();
    check("g_retire", 64'(retire_count), 64'd4);
    check("g_prf", 64'(RRAT_PRF_idx), {40'd0, 6'd43, 6'd42, 6'd41, 6'd40});
    check("g_arf", 64'(RRAT_ARF_idx), {44'd0, 5'd12, 5'd11, 5'd10, 5'd9});
    check("g_rrat_v", 64'(RRAT_idx_valid), 64'hF);
    tick();
    check("g_head", 64'(disp_rob_idx[0]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_retire_queue.md
Name: rob_retire_queue

Overview:
- In-order reorder buffer sitting between dispatch/CDB and the RAT/RRAT block.
- Accepts up to WAYS renamed instructions per cycle and records CDB completions.
- Retires up to WAYS completed instructions per cycle from the head. Retirement drives the RRAT commit lanes (ARF#, PRF#, valid).
- On retirement of a mispredicted branch it raises except, which flushes itself and restores the RAT from the RRAT.

Parameters:
WAYS, 4, superscalar width for dispatch, complete and retire
PRF, 64, physical register count; PRF index width is $clog2(PRF)
ROB_DEPTH, 32, entry count; must be a power of 2 and at least WAYS

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
disp_valid  in  WAYS  dispatch lanes; valid bits contiguous from lane 0
disp_arf_idx  in  WAYS x 5  architectural destination
disp_prf_idx  in  WAYS x $clog2(PRF)  renamed destination PRF#
disp_has_dest  in  WAYS  instruction writes a register
disp_accept  out  WAYS  lane accepted this cycle (combinational)
disp_rob_idx  out  WAYS x $clog2(ROB_DEPTH)  entry assigned to each lane
cdb_valid  in  WAYS  completion broadcasts
cdb_rob_idx  in  WAYS x $clog2(ROB_DEPTH)  completing entry
cdb_mispredict  in  WAYS  completing entry is a mispredicted branch
RRAT_ARF_idx  out  WAYS x 5  retire lane ARF#
RRAT_PRF_idx  out  WAYS x $clog2(PRF)  retire lane PRF#
RRAT_idx_valid  out  WAYS  retire lane updates RRAT
except  out  1  mispredicted branch retires this cycle
retire_count  out  $clog2(WAYS+1)  entries retired this cycle
free_slots  out  $clog2(ROB_DEPTH+1)  registered free entry count

Behaviour:
State and reset:
- State: entry array, head ptr, tail ptr, count register.
- On reset low: head=tail=0, count=0, all entry valid/complete/mispredict cleared.
- Reset values of outputs: RRAT_idx_valid=0, except=0, retire_count=0, free_slots=ROB_DEPTH.

Dispatch:
- disp_accept[i] = disp_valid[i] & (i < free_slots) & ~except.
- free_slots = ROB_DEPTH-count, from the registered count only. Same-cycle retirement gives no credit.
- disp_rob_idx[i] = (tail+i) mod ROB_DEPTH.
- Accepted lanes are written at the clock edge: valid=1, complete=0, mispredict=0.
- tail advances by popcount(disp_accept), wrapping modulo ROB_DEPTH.
- Rejected lanes are dropped; the upstream stage re-presents them.
- Full (count==ROB_DEPTH): disp_accept=0.

Completion:
- At the edge, each cdb_valid lane sets complete=1 on its entry, and sets mispredict when cdb_mispredict is asserted.
- A broadcast to an invalid entry is ignored.
- A completion becomes visible to retirement in the next cycle (1-cycle latency).
- Duplicate broadcasts to the same entry are idempotent.

Retirement (combinational from registered state):
- Lane k examines entry (head+k) mod ROB_DEPTH.
- Lane k retires iff the entry is valid & complete, lane k-1 retired, and no earlier lane this cycle was mispredicted.
- A mispredicted entry itself retires, and the lanes after it are 0.
- RRAT_idx_valid[k] = retires & has_dest & (arf_idx != 0). Non-dest and x0 entries retire without an RRAT write.
- except = 1 iff some retiring lane is mispredicted. RRAT lanes up to and including that lane remain valid in the same cycle.
- head advances by retire_count; retired entries are cleared.
- Empty (count==0): nothing retires.

Flush:
- When except=1, at the edge: head=tail=0, count=0, all entries cleared.
- Dispatch is suppressed that cycle; CDB completions that cycle are discarded.

Count and simultaneous events:
- count_next = count + accepted - retired.
- Dispatch, completion and retirement all in the same cycle are legal.
- An entry being retired cannot be the target of same-cycle dispatch, because free_slots excludes it.

Reset mid-operation:
- Asynchronous clear regardless of clock.
- Outputs settle to their reset values while reset is low.

Decomposition:
- Shared package holds:
  - rob_entry_t: valid, complete, mispredict, has_dest, arf_idx[4:0], prf_idx[$clog2(PRF)-1:0].
  - ROB_IDX_W, PRF_IDX_W constants.
- One sub-module, rob_retire_select (combinational). Input: WAYS head entries. Output: retire mask, RRAT lanes, except, retire_count.

Test Plan:
- Reset low mid-run with count=10 -> next cycle free_slots=32, RRAT_idx_valid=0, except=0, head=tail=0.
- Dispatch 4 lanes (arf 1,2,3,0, has_dest 1,1,1,0), CDB all 4 next cycle -> one cycle later retire_count=4, RRAT_idx_valid=4'b0111, RRAT_PRF_idx matches disp_prf_idx.
- Fill to 30 entries, present 4 lanes -> disp_accept=4'b0011, free_slots=0 next cycle, tail wraps to head.
- Complete entries 0,2,3 (entry 1 pending) -> retire_count=1. After completing entry 1 -> retire_count=3, head=4.
- Entries 0..3 complete, entry 1 mispredicted -> RRAT_idx_valid=4'b0011, except=1. Same-cycle disp_accept=0; next cycle count=0, head=tail=0.
- With head at 30, dispatch 4 and complete all -> retire lanes read entries 30,31,0,1 in order, retire_count=4.
